// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the data RAM arbiter.
package mem_arb_pkg;

  typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_t;

  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_MAX_WAIT = 4;

  // Word index of a byte address; the caller keeps the low ADDR_W bits (wrap).
  function automatic logic [29:0] byte_to_word(input logic [31:0] addr);
    return addr[31:2];
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Combinational grant logic: A has priority unless B has waited MAX_WAIT cycles.
module mem_arb_select #(
  parameter int MAX_WAIT = 4
) (
  input  logic       a_req,
  input  logic       b_req,
  input  logic [3:0] starve_cnt,
  output logic       a_gnt,
  output logic       b_gnt
);

  logic starved;

  assign starved = (starve_cnt == 4'(MAX_WAIT));
  assign b_gnt   = b_req && (starved || !a_req);
  assign a_gnt   = a_req && !b_gnt;

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data RAM with
// one-cycle read latency; read data is steered back to the issuing port.
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [31:0]       a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [31:0]       b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  logic [3:0]  starve_cnt;
  logic        rd_pending;
  owner_t      rd_owner;
  logic        gnt, sel_we, aligned, rd_issue;
  logic [31:0] sel_addr;
  logic [29:0] sel_word;
  logic        unused_word;

  // No access is granted while reset is held, so the RAM sees no traffic.
  mem_arb_select #(.MAX_WAIT(MAX_WAIT)) u_select (
    .a_req      (a_req && !rst),
    .b_req      (b_req && !rst),
    .starve_cnt (starve_cnt),
    .a_gnt      (a_gnt),
    .b_gnt      (b_gnt)
  );

  assign gnt      = a_gnt | b_gnt;
  assign sel_addr = b_gnt ? b_addr : a_addr;
  assign sel_we   = b_gnt ? b_we   : a_we;
  assign sel_word = byte_to_word(sel_addr);
  assign aligned  = (sel_addr[1:0] == 2'b00);
  assign rd_issue = gnt && !sel_we && aligned;
  assign unused_word = ^sel_word;

  assign mem_addr  = gnt ? sel_word[ADDR_W-1:0] : '0;
  assign mem_wdata = gnt ? (b_gnt ? b_wdata : a_wdata) : '0;
  assign mem_wren  = gnt && sel_we && aligned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pending <= 1'b0;
      rd_owner   <= OWN_A;
      a_err      <= 1'b0;
      b_err      <= 1'b0;
    end else begin
      rd_pending <= rd_issue;
      if (rd_issue) rd_owner <= b_gnt ? OWN_B : OWN_A;
      a_err <= a_gnt && !aligned;
      b_err <= b_gnt && !aligned;
    end
  end

  // Counts consecutive denied B cycles; saturates so B wins on the next try.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       starve_cnt <= '0;
    else if (!b_req || b_gnt)      starve_cnt <= '0;
    else if (starve_cnt != 4'(MAX_WAIT)) starve_cnt <= starve_cnt + 4'd1;
  end

  assign a_rvalid = rd_pending && (rd_owner == OWN_A);
  assign b_rvalid = rd_pending && (rd_owner == OWN_B);
  assign a_rdata  = a_rvalid ? mem_q : '0;
  assign b_rdata  = b_rvalid ? mem_q : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed + randomized bench for data_mem_arbiter with a behavioural RAM and
// a cycle-level reference model of grants, returns and errors.
module tb_data_mem_arbiter;
  localparam int ADDR_W = 8, DATA_W = 32, MAX_WAIT = 4, WORDS = 256;

  logic clk = 1'b0, rst = 1'b1;
  logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [31:0] a_addr = 0, b_addr = 0, a_wdata = 0, b_wdata = 0;
  logic a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err, mem_wren;
  logic [31:0] a_rdata, b_rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_q = 0;
  logic [31:0] ram [WORDS];

  int vectors = 0, miscompares = 0;

  // reference model state
  bit [31:0] shadow [WORDS];
  int        denied = 0;
  bit        exp_a_rv = 0, exp_b_rv = 0, exp_a_err = 0, exp_b_err = 0;
  bit [31:0] exp_rd = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  initial for (int i = 0; i < WORDS; i++) ram[i] = '0;

  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr] <= mem_wdata;
    mem_q <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " gnt"},   {a_gnt, b_gnt, mem_wren}, 0);
    chk({tag, " mem"},   {mem_addr, mem_wdata}, 0);
    chk({tag, " rv"},    {a_rvalid, b_rvalid, a_err, b_err}, 0);
    chk({tag, " rdata"}, {a_rdata, b_rdata}, 0);
  endtask

  task automatic step(input bit ar, input bit awe, input logic [31:0] aad, input logic [31:0] awd,
                      input bit br, input bit bwe, input logic [31:0] bad, input logic [31:0] bwd);
    bit bw, aw, g, we, al;
    logic [31:0] ad, wd;
    int w;
    @(negedge clk);
    a_req = ar; a_we = awe; a_addr = aad; a_wdata = awd;
    b_req = br; b_we = bwe; b_addr = bad; b_wdata = bwd;
    #1;
    bw = br && (denied == MAX_WAIT || !ar);
    aw = ar && !bw;
    g  = aw || bw;
    ad = bw ? bad : aad;
    wd = bw ? bwd : awd;
    we = bw ? bwe : awe;
    al = (ad % 4) == 0;
    w  = int'((ad / 4) % WORDS);
    chk("a_gnt", a_gnt, aw);
    chk("b_gnt", b_gnt, bw);
    chk("mem_wren", mem_wren, g && we && al);
    chk("mem_addr", mem_addr, g ? w : 0);
    chk("mem_wdata", mem_wdata, g ? wd : 0);
    chk("a_rvalid", a_rvalid, exp_a_rv);
    chk("a_rdata", a_rdata, exp_a_rv ? exp_rd : 0);
    chk("b_rvalid", b_rvalid, exp_b_rv);
    chk("b_rdata", b_rdata, exp_b_rv ? exp_rd : 0);
    chk("a_err", a_err, exp_a_err);
    chk("b_err", b_err, exp_b_err);
    exp_a_rv  = aw && !we && al;
    exp_b_rv  = bw && !we && al;
    exp_rd    = shadow[w];
    if (g && we && al) shadow[w] = wd;
    exp_a_err = aw && !al;
    exp_b_err = bw && !al;
    if (!br || bw) denied = 0;
    else if (denied < MAX_WAIT) denied++;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] pool [4];
    pool[0] = 32'h10; pool[1] = 32'h14; pool[2] = 32'h20; pool[3] = 32'h24;

    // reset state
    @(negedge clk); #1;
    chk_idle_outputs("reset");
    @(negedge clk); rst = 0;

    // A write then A read of the same address
    step(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
    step(1, 0, 32'h10, 0,            0, 0, 0, 0);
    idle();

    // both ports held: B wins after MAX_WAIT denials
    repeat (10) step(1, 0, 32'h14, 0, 1, 0, 32'h18, 0);
    idle();

    // alternating reads return in grant order
    step(1, 1, 32'h20, 32'h11, 0, 0, 0, 0);
    step(0, 0, 0, 0,           1, 1, 32'h24, 32'h22);
    step(1, 0, 32'h20, 0,      0, 0, 0, 0);
    step(0, 0, 0, 0,           1, 0, 32'h24, 0);
    idle();

    // misaligned B write is consumed but suppressed
    step(0, 0, 0, 0, 1, 1, 32'h13, 32'h5555AAAA);
    step(1, 0, 32'h10, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 32'h11, 0);
    idle();

    // address bits above the RAM range wrap
    step(1, 1, 32'h0, 32'h600D600D, 0, 0, 0, 0);
    step(1, 0, 32'h400, 0, 0, 0, 0, 0);
    idle();

    // read granted, then asynchronous reset before the return edge
    step(1, 0, 32'h20, 0, 0, 0, 0, 0);
    #2 rst = 1;
    #1 chk_idle_outputs("in_reset");
    exp_a_rv = 0; exp_b_rv = 0; exp_a_err = 0; exp_b_err = 0; denied = 0;
    a_req = 0; b_req = 0;
    @(posedge clk); #1 chk_idle_outputs("after_edge_in_reset");
    @(negedge clk); rst = 0;
    step(1, 0, 32'h20, 0, 0, 0, 0, 0);
    idle();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] aa, ba;
      aa = pool[$urandom_range(0, 3)] | ($urandom_range(0, 3) << 10);
      ba = pool[$urandom_range(0, 3)] | ($urandom_range(0, 3) << 10);
      if ($urandom_range(0, 7) == 0) aa = aa | $urandom_range(1, 3);
      if ($urandom_range(0, 7) == 0) ba = ba | $urandom_range(1, 3);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, aa, $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, ba, $urandom);
    end
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
